viterbi_frame_ctrl: RTL and testbench
=====================================

// Module: viterbi_frame_ctrl
// PURPOSE
//  Frame sequencer and self-check controller for the convolutional-encoder / channel / Viterbi-decoder path.
//  Accepts payload bits by valid/ready and drives the encoder enable and data, appending zero tail bits to flush.
//  Schedules channel error injection as a 2-bit XOR mask and compares decoder output against delayed payload.
//  Counts injected errors and residual bit errors per frame.
// PARAMETERS
//  FRAME_LEN  64   payload bits per frame (>=1)
//  TAIL_LEN   2    zero flush bits after payload (K-1 of encoder)
//  ENC_LAT    1    clocks from enc_en_o to encoder symbol at channel register
//  DEC_LAT    8    clocks from enc_en_o of a bit to that bit on dec_bit_i (>=1)
//  ERR_SHIFT  4    inject every 2**ERR_SHIFT encoded cycles
//  ERR_WINDOW 256  no injection at or beyond this encoded-cycle index
//  CNT_W      16   width of statistics counters
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active low
//  start_i      in   1      start one frame (honoured in IDLE only)
//  inj_en_i     in   1      enable error injection, sampled at start
//  bit_valid_i  in   1      payload bit offered
//  bit_i        in   1      payload bit
//  bit_ready_o  out  1      controller accepts bit this cycle
//  enc_en_o     out  1      encoder enable
//  enc_bit_o    out  1      encoder data input
//  err_mask_o   out  2      XOR mask for channel symbol register
//  dec_bit_i    in   1      decoder output bit
//  busy_o       out  1      frame in progress
//  done_o       out  1      one-cycle pulse, frame complete
//  inj_ct_o     out  CNT_W  injected mask pulses this frame
//  bit_err_ct_o out  CNT_W  payload bits where dec_bit_i != sent bit
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, all outputs 0, all counters and delay lines cleared.
//  States: IDLE -> PAYLOAD -> TAIL -> DRAIN -> IDLE.
//   IDLE:   start_i=1 -> PAYLOAD next clk; counters cleared, inj_en_i latched. start_i ignored outside IDLE.
//   PAYLOAD: bit_ready_o=1. Accept when bit_valid_i&bit_ready_o; next clk enc_en_o=1, enc_bit_o=bit_i.
//            No accept -> enc_en_o=0 next clk (bubble), payload count unchanged.
//            FRAME_LEN-th accept -> TAIL.
//   TAIL:   enc_en_o=1, enc_bit_o=0 for TAIL_LEN clocks; bit_ready_o=0; then DRAIN.
//   DRAIN:  wait until last payload compare done (DEC_LAT clocks after last tail enc_en_o); done_o=1 one clk; -> IDLE.
//  busy_o=1 in PAYLOAD/TAIL/DRAIN. Counters hold after done until next start.
//  Injection: enc_idx counts enc_en_o=1 cycles from 0 per frame (payload+tail).
//   At enc_idx with idx[ERR_SHIFT-1:0]=='1, idx<ERR_WINDOW, latched inj_en=1:
//   err_mask_o=2'b01 exactly ENC_LAT clocks after that enc_en_o cycle, else 2'b00; inj_ct_o++.
//  Compare: a tagged shift register of depth DEC_LAT carries {valid,bit} per clock; tag=1 only for payload bits.
//   Tag emerging with valid=1: dec_bit_i compared; mismatch -> bit_err_ct_o++. Tail bits and bubbles never compared.
//  Counters saturate at all-ones (no wrap).
//  start_i on the done_o cycle is ignored (state not yet IDLE).
//  rst asserted mid-frame: abort immediately, no done_o, stats cleared.
// STRUCTURE
//  Shared package viterbi_pkg: state enum vfc_state_t {IDLE,PAYLOAD,TAIL,DRAIN}, ERR_MASK=2'b01, default CNT_W.
//  Sub-module vfc_ref_delay: parameterised DEC_LAT-deep {valid,bit} shift line with async active-low clear.
//  Top holds FSM, payload/tail/enc_idx counters, injection scheduler, saturating stat counters.
// TESTING
//  1 Clean: defaults, inj_en_i=0, 64 bits always valid, ideal decoder model -> 66 enc_en_o pulses, inj_ct_o=0, bit_err_ct_o=0, done_o once.
//  2 Injection: inj_en_i=1, ERR_SHIFT=4 -> mask 2'b01 at enc_idx 15,31,47,63 (ENC_LAT later), inj_ct_o=4.
//  3 Stall: drop bit_valid_i 5 clk after bit 20 -> 5-clk enc_en_o gap, done_o 5 clk later than test 1, bit_err_ct_o=0.
//  4 Mismatch: decoder model inverts payload bits 3 and 40 -> bit_err_ct_o=2; inverting tail bits -> no change.
//  5 Start rules: start_i during PAYLOAD and on done_o cycle -> ignored; start next clk -> new frame, counters cleared.
//  6 Reset mid-PAYLOAD at bit 30 -> all outputs 0 same cycle, no done_o; next start runs clean frame as test 1.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi frame sequencer.
package viterbi_pkg;
   typedef enum logic [1:0] {IDLE, PAYLOAD, TAIL, DRAIN} vfc_state_t;
   localparam logic [1:0] ERR_MASK  = 2'b01;
   localparam int         CNT_W_DEF = 16;
endpackage

// File: rtl/vfc_ref_delay.sv
// DEPTH-deep {valid,bit} delay line aligning sent payload with decoder output.
module vfc_ref_delay #(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic in_vld,
   input  logic in_bit,
   output logic out_vld,
   output logic out_bit
);
   logic [DEPTH-1:0] vld_pipe;
   logic [DEPTH-1:0] bit_pipe;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         bit_pipe <= '0;
      end else begin
         vld_pipe[0] <= in_vld;
         bit_pipe[0] <= in_bit;
         for (int i = 1; i < DEPTH; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            bit_pipe[i] <= bit_pipe[i-1];
         end
      end
   end

   assign out_vld = vld_pipe[DEPTH-1];
   assign out_bit = bit_pipe[DEPTH-1];
endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: feeds the encoder, schedules channel error injection and
// counts residual decoder bit errors against the delayed payload.
module viterbi_frame_ctrl
   import viterbi_pkg::*;
#(
   parameter int FRAME_LEN  = 64,
   parameter int TAIL_LEN   = 2,
   parameter int ENC_LAT    = 1,
   parameter int DEC_LAT    = 8,
   parameter int ERR_SHIFT  = 4,
   parameter int ERR_WINDOW = 256,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             inj_en_i,
   input  logic             bit_valid_i,
   input  logic             bit_i,
   output logic             bit_ready_o,
   output logic             enc_en_o,
   output logic             enc_bit_o,
   output logic [1:0]       err_mask_o,
   input  logic             dec_bit_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] inj_ct_o,
   output logic [CNT_W-1:0] bit_err_ct_o
);
   vfc_state_t         state_q, state_d;
   logic [31:0]        ph_cnt;
   logic [31:0]        enc_idx;
   logic               inj_en_q;
   logic               enc_pay_q;
   logic [ENC_LAT-1:0] hit_pipe;
   logic               accept, frame_start, inj_hit;
   logic               ref_vld, ref_bit, cmp_err;

   assign bit_ready_o = (state_q == PAYLOAD);
   assign busy_o      = (state_q != IDLE);
   assign accept      = bit_ready_o && bit_valid_i;
   assign frame_start = (state_q == IDLE) && start_i;
   assign done_o      = (state_q == DRAIN) && (ph_cnt == 32'(DEC_LAT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = PAYLOAD;
         PAYLOAD: if (accept && ph_cnt == 32'(FRAME_LEN - 1)) state_d = TAIL;
         TAIL:    if (ph_cnt == 32'(TAIL_LEN - 1)) state_d = DRAIN;
         DRAIN:   if (done_o) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ph_cnt counts accepts in PAYLOAD and clocks in TAIL/DRAIN; restarts on every state change
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph_cnt <= '0;
      end else if (state_d != state_q) begin
         ph_cnt <= '0;
      end else if ((state_q == PAYLOAD) ? accept : (state_q != IDLE)) begin
         ph_cnt <= ph_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enc_en_o  <= 1'b0;
         enc_bit_o <= 1'b0;
         enc_pay_q <= 1'b0;
         enc_idx   <= '0;
         inj_en_q  <= 1'b0;
      end else begin
         enc_en_o  <= accept || (state_q == TAIL);
         enc_bit_o <= accept && bit_i;
         enc_pay_q <= accept;
         if (frame_start) begin
            enc_idx  <= '0;
            inj_en_q <= inj_en_i;
         end else if (enc_en_o) begin
            enc_idx  <= enc_idx + 32'd1;
         end
      end
   end

   assign inj_hit = enc_en_o && inj_en_q && (&enc_idx[ERR_SHIFT-1:0]) &&
                    (enc_idx < 32'(ERR_WINDOW));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_pipe <= '0;
      end else begin
         hit_pipe[0] <= inj_hit;
         for (int i = 1; i < ENC_LAT; i++) hit_pipe[i] <= hit_pipe[i-1];
      end
   end

   assign err_mask_o = hit_pipe[ENC_LAT-1] ? ERR_MASK : 2'b00;

   // only payload bits are tagged, so tail bits and bubbles never reach the comparator
   vfc_ref_delay #(.DEPTH(DEC_LAT)) u_ref_delay (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (enc_pay_q),
      .in_bit  (enc_bit_o),
      .out_vld (ref_vld),
      .out_bit (ref_bit)
   );

   assign cmp_err = ref_vld && (dec_bit_i != ref_bit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inj_ct_o     <= '0;
         bit_err_ct_o <= '0;
      end else if (frame_start) begin
         inj_ct_o     <= '0;
         bit_err_ct_o <= '0;
      end else begin
         if (inj_hit && inj_ct_o != '1)     inj_ct_o     <= inj_ct_o + 1'b1;
         if (cmp_err && bit_err_ct_o != '1) bit_err_ct_o <= bit_err_ct_o + 1'b1;
      end
   end
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl with an ideal-decoder model.
module tb_viterbi_frame_ctrl;
   localparam int FRAME_LEN  = 64;
   localparam int TAIL_LEN   = 2;
   localparam int ENC_LAT    = 1;
   localparam int DEC_LAT    = 8;
   localparam int ERR_SHIFT  = 4;
   localparam int ERR_WINDOW = 256;
   localparam int CNT_W      = 16;

   logic             clk, rst, start_i, inj_en_i, bit_valid_i, bit_i, dec_bit_i;
   logic             bit_ready_o, enc_en_o, enc_bit_o, busy_o, done_o;
   logic [1:0]       err_mask_o;
   logic [CNT_W-1:0] inj_ct_o, bit_err_ct_o;

   viterbi_frame_ctrl #(
      .FRAME_LEN(FRAME_LEN), .TAIL_LEN(TAIL_LEN), .ENC_LAT(ENC_LAT), .DEC_LAT(DEC_LAT),
      .ERR_SHIFT(ERR_SHIFT), .ERR_WINDOW(ERR_WINDOW), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .inj_en_i(inj_en_i),
      .bit_valid_i(bit_valid_i), .bit_i(bit_i), .bit_ready_o(bit_ready_o),
      .enc_en_o(enc_en_o), .enc_bit_o(enc_bit_o), .err_mask_o(err_mask_o),
      .dec_bit_i(dec_bit_i), .busy_o(busy_o), .done_o(done_o),
      .inj_ct_o(inj_ct_o), .bit_err_ct_o(bit_err_ct_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit inj; int stall; int ia; int ib; bit itail;
      int exp_enc; int exp_inj; int exp_err; int exp_lat;
   } vec_t;

   int checks = 0, fails = 0;
   int cyc = 0, enc_cnt = 0, acc_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
   int stall_left = 0, inv_a = -1, inv_b = -1;
   bit cfg_inj = 0, inv_tail = 0;
   bit pay [FRAME_LEN];
   bit exp_bits [$];
   int mask_q [$];
   bit hv [64];
   bit hb [64];
   int hi [64];
   bit eb, em, inv;
   int j;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor, scoreboard and ideal decoder model, all evaluated mid-cycle
   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (bit_ready_o && bit_valid_i) begin
            exp_bits.push_back(bit_i);
            acc_cnt++;
            if (acc_cnt == FRAME_LEN)
               for (int k = 0; k < TAIL_LEN; k++) exp_bits.push_back(1'b0);
         end
         hv[cyc % 64] = enc_en_o;
         hb[cyc % 64] = enc_bit_o;
         hi[cyc % 64] = enc_cnt;
         if (enc_en_o) begin
            if (exp_bits.size() == 0) chk("enc_unexpected", 1, 0);
            else begin
               eb = exp_bits.pop_front();
               chk("enc_bit", longint'(enc_bit_o), longint'(eb));
            end
            if (cfg_inj && (enc_cnt % (1 << ERR_SHIFT)) == (1 << ERR_SHIFT) - 1 &&
                enc_cnt < ERR_WINDOW)
               mask_q.push_back(cyc + ENC_LAT);
            enc_cnt++;
         end
         em = 0;
         if (mask_q.size() > 0 && mask_q[0] == cyc) begin
            em = 1;
            void'(mask_q.pop_front());
         end
         if (em || err_mask_o != 2'b00) chk("err_mask", longint'(err_mask_o), em ? 1 : 0);
         if (cyc >= DEC_LAT) begin
            j = (cyc - DEC_LAT) % 64;
            inv = hv[j] && (hi[j] == inv_a || hi[j] == inv_b || (inv_tail && hi[j] >= FRAME_LEN));
            dec_bit_i = hb[j] ^ inv;
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
      cyc++;
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, longint'(bit_ready_o), 0);
      chk({tag, "_enc_en"}, longint'(enc_en_o), 0);
      chk({tag, "_enc_bit"}, longint'(enc_bit_o), 0);
      chk({tag, "_mask"}, longint'(err_mask_o), 0);
      chk({tag, "_busy"}, longint'(busy_o), 0);
      chk({tag, "_done"}, longint'(done_o), 0);
      chk({tag, "_inj_ct"}, longint'(inj_ct_o), 0);
      chk({tag, "_err_ct"}, longint'(bit_err_ct_o), 0);
   endtask

   task automatic run_frame(input bit inj, input int stall, input int ia, input int ib,
                            input bit itail, input bit nowait, input int pa, input int pb,
                            input int abort_acc, output int lat);
      bit fin;
      int rel;
      fin = 0;
      lat = -1;
      cfg_inj = inj; inv_a = ia; inv_b = ib; inv_tail = itail;
      exp_bits.delete(); mask_q.delete();
      enc_cnt = 0; acc_cnt = 0; done_cnt = 0; stall_left = stall;
      for (int k = 0; k < FRAME_LEN; k++) pay[k] = 1'($urandom);
      if (!nowait) begin @(posedge clk); #1; end
      start_i = 1; inj_en_i = inj; start_cyc = cyc; bit_valid_i = 1; bit_i = pay[0];
      for (int t = 0; t < 300 && !fin; t++) begin
         @(posedge clk); #1;
         rel = cyc - start_cyc;
         start_i  = (rel == pa) || (rel == pb);
         inj_en_i = 0;
         if (done_cnt > 0) begin
            lat = done_cyc - start_cyc;
            fin = 1;
         end else if (abort_acc >= 0 && acc_cnt == abort_acc) begin
            rst = 0;
            #1;
            chk_all_zero("abort");
            fin = 1;
         end else begin
            if (acc_cnt == 21 && stall_left > 0) begin
               bit_valid_i = 0;
               stall_left--;
            end else bit_valid_i = 1;
            bit_i = pay[acc_cnt % FRAME_LEN];
         end
      end
      bit_valid_i = 0;
      if (!fin) chk("frame_timeout", 0, 1);
   endtask

   task automatic chk_frame(input string tag, input vec_t v, input int lat);
      chk({tag, "_latency"}, lat, v.exp_lat);
      chk({tag, "_enc_pulses"}, enc_cnt, v.exp_enc);
      chk({tag, "_inj_ct"}, longint'(inj_ct_o), v.exp_inj);
      chk({tag, "_err_ct"}, longint'(bit_err_ct_o), v.exp_err);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_mask_pending"}, mask_q.size(), 0);
   endtask

   initial begin
      vec_t vecs [4];
      vec_t clean;
      int lat;
      vecs[0] = '{0, 0, -1, -1, 0, 66, 0, 0, 75};  // clean
      vecs[1] = '{1, 0, -1, -1, 0, 66, 4, 0, 75};  // injection
      vecs[2] = '{0, 5, -1, -1, 0, 66, 0, 0, 80};  // 5-clock stall after bit 20
      vecs[3] = '{0, 0, 3, 40, 1, 66, 0, 2, 75};   // payload 3,40 and tail inverted
      clean = vecs[0];

      rst = 0; start_i = 0; inj_en_i = 0; bit_valid_i = 0; bit_i = 0; dec_bit_i = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1;

      for (int i = 0; i < 4; i++) begin
         run_frame(vecs[i].inj, vecs[i].stall, vecs[i].ia, vecs[i].ib, vecs[i].itail,
                   0, -1, -1, -1, lat);
         chk_frame($sformatf("vec%0d", i), vecs[i], lat);
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("vec%0d_idle_busy", i), longint'(busy_o), 0);
         chk($sformatf("vec%0d_hold_inj", i), longint'(inj_ct_o), vecs[i].exp_inj);
         chk($sformatf("vec%0d_hold_err", i), longint'(bit_err_ct_o), vecs[i].exp_err);
      end

      // start during PAYLOAD and on the done cycle are ignored; start one clock later is honoured
      run_frame(1, 0, -1, -1, 0, 0, 10, 75, -1, lat);
      chk_frame("start_rules", vecs[1], lat);
      chk("start_on_done_ignored", longint'(busy_o), 0);
      chk("start_rules_hold_inj", longint'(inj_ct_o), 4);
      run_frame(0, 0, -1, -1, 0, 1, -1, -1, -1, lat);
      chk_frame("restart", clean, lat);

      // reset mid-payload at bit 30
      run_frame(0, 0, -1, -1, 0, 0, -1, -1, 30, lat);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);
      chk_all_zero("abort_hold");
      rst = 1;
      run_frame(0, 0, -1, -1, 0, 0, -1, -1, -1, lat);
      chk_frame("post_abort", clean, lat);

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
